// File: rtl/div_ctrl_pkg.sv
// Shared defines for the EX-stage divide controller.
// Widths, result select encoding and FSM state encoding.
package div_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int DIV_CYCLES = 33;

    localparam logic RES_QUO = 1'b0;
    localparam logic RES_REM = 1'b1;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_BUSY = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    typedef struct packed {
        logic            sign;
        logic            rem;
        logic [4:0]      rd;
        logic [XLEN-1:0] dividend;
        logic [XLEN-1:0] divisor;
    } div_req_t;

    function automatic logic [XLEN-1:0] sel_result(
        input logic            rem,
        input logic [XLEN-1:0] quo,
        input logic [XLEN-1:0] rmd
    );
        return (rem == RES_REM) ? rmd : quo;
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Bundle between EX pipeline, iterative divider and div_ctrl.
// slave = controller side, master = pipeline/divider side.
interface div_ctrl_if;
    import div_ctrl_pkg::*;

    logic            req_valid;
    logic            req_sign;
    logic            req_rem;
    logic [4:0]      req_rd;
    logic [XLEN-1:0] req_dividend;
    logic [XLEN-1:0] req_divisor;
    logic            flush;
    logic            stall;

    logic            div_start;
    logic            div_sign;
    logic            div_res_sel;
    logic [XLEN-1:0] div_dividend;
    logic [XLEN-1:0] div_divisor;
    logic            div_done;
    logic [XLEN-1:0] div_res;

    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    modport slave (
        input  req_valid, req_sign, req_rem, req_rd,
        input  req_dividend, req_divisor, flush,
        input  div_done, div_res,
        output stall,
        output div_start, div_sign, div_res_sel,
        output div_dividend, div_divisor,
        output wb_valid, wb_rd, wb_data
    );

    modport master (
        output req_valid, req_sign, req_rem, req_rd,
        output req_dividend, req_divisor, flush,
        output div_done, div_res,
        input  stall,
        input  div_start, div_sign, div_res_sel,
        input  div_dividend, div_divisor,
        input  wb_valid, wb_rd, wb_data
    );

endinterface

// File: rtl/div_ctrl_special_case.sv
// Divide-by-zero and signed-overflow detection for div_ctrl.
// These results are known up front and skip the divider.
module div_special_case
    import div_ctrl_pkg::*;
(
    input  logic            sign,
    input  logic            rem,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            special,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    logic div_zero;
    logic overflow;

    // Classify the operands and build the architectural result
    always_comb begin
        div_zero = (divisor == '0);
        overflow = sign && (dividend == MIN_NEG) && (divisor == ALL_ONES);
        special  = div_zero || overflow;
        result   = '0;
        if (div_zero) begin
            result = sel_result(rem, ALL_ONES, dividend);
        end else if (overflow) begin
            result = sel_result(rem, MIN_NEG, '0);
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// EX-stage controller for DIV/DIVU/REM/REMU.
// Sequences the external divider, stalls EX, emits writeback.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    div_ctrl_if.slave bus
);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    div_req_t        lat;
    logic [4:0]      res_rd;
    logic [XLEN-1:0] res_data;
    logic            special;
    logic [XLEN-1:0] bypass_res;
    logic            accept;
    logic            go_busy;
    logic            go_bypass;
    logic            abort;
    logic            finish;
    logic            live;

    div_special_case u_special (
        .sign     (bus.req_sign),
        .rem      (bus.req_rem),
        .dividend (bus.req_dividend),
        .divisor  (bus.req_divisor),
        .special  (special),
        .result   (bypass_res)
    );

    // Qualify request and divider completion against flush
    always_comb begin
        accept    = (state == S_IDLE) && bus.req_valid && !bus.flush;
        go_busy   = accept && !special;
        go_bypass = accept && special;
        abort     = (state == S_BUSY) && bus.flush;
        finish    = (state == S_BUSY) && bus.div_done && !bus.flush;
    end

    // Next state; DONE always lasts exactly one cycle
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (go_busy) begin
                    state_nxt = S_BUSY;
                end else if (go_bypass) begin
                    state_nxt = S_DONE;
                end
            end
            S_BUSY: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (finish) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register; reset also aborts an in-flight division
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Hold operands steady for the divider during BUSY
    always_ff @(posedge clk) begin
        if (rst_n) begin
            lat <= '0;
        end else if (go_busy) begin
            lat.sign     <= bus.req_sign;
            lat.rem      <= bus.req_rem;
            lat.rd       <= bus.req_rd;
            lat.dividend <= bus.req_dividend;
            lat.divisor  <= bus.req_divisor;
        end
    end

    // Capture the result from the bypass or the divider
    always_ff @(posedge clk) begin
        if (rst_n) begin
            res_rd   <= '0;
            res_data <= '0;
        end else if (go_bypass) begin
            res_rd   <= bus.req_rd;
            res_data <= bypass_res;
        end else if (finish) begin
            res_rd   <= lat.rd;
            res_data <= bus.div_res;
        end
    end

    // Drive outputs; all held low while reset is asserted
    always_comb begin
        live             = !rst_n;
        bus.stall        = live && (accept || (state == S_BUSY));
        bus.div_start    = live && (state == S_BUSY);
        bus.div_sign     = live && lat.sign;
        bus.div_res_sel  = live && lat.rem;
        bus.div_dividend = lat.dividend & {XLEN{live}};
        bus.div_divisor  = lat.divisor & {XLEN{live}};
        bus.wb_valid     = live && (state == S_DONE);
        bus.wb_rd        = res_rd & {5{live}};
        bus.wb_data      = res_data & {XLEN{live}};
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl with a behavioural divider.
// Directed vectors with hand-computed results and latencies.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    div_ctrl_if bus ();

    div_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int dcnt   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural divider: done on the 34th start cycle
    always @(posedge clk) dcnt <= bus.div_start ? dcnt + 1 : 0;

    logic [31:0] quo;
    logic [31:0] rmd;
    always_comb begin
        quo = 32'hFFFF_FFFF;
        rmd = bus.div_dividend;
        if (bus.div_divisor != 32'd0) begin
            if (bus.div_sign) begin
                if (bus.div_dividend == 32'h8000_0000 &&
                    bus.div_divisor == 32'hFFFF_FFFF) begin
                    quo = 32'h8000_0000;
                    rmd = 32'd0;
                end else begin
                    quo = 32'($signed(bus.div_dividend) / $signed(bus.div_divisor));
                    rmd = 32'($signed(bus.div_dividend) % $signed(bus.div_divisor));
                end
            end else begin
                quo = bus.div_dividend / bus.div_divisor;
                rmd = bus.div_dividend % bus.div_divisor;
            end
        end
        bus.div_done = bus.div_start && (dcnt == DIV_CYCLES);
        bus.div_res  = bus.div_res_sel ? rmd : quo;
    end

    typedef struct {
        string       name;
        logic [4:0]  rd;
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t sbq[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every writeback must match the head of the scoreboard
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.wb_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb: got rd=%0d data=%h, expected none",
                         bus.wb_rd, bus.wb_data);
            end else begin
                e = sbq.pop_front();
                check({e.name, "_data"}, bus.wb_data, e.data);
                check({e.name, "_rd"}, 32'(bus.wb_rd), 32'(e.rd));
                check({e.name, "_cycle"}, 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sign, input logic rem, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b);
        bus.req_valid    = 1'b1;
        bus.req_sign     = sign;
        bus.req_rem      = rem;
        bus.req_rd       = rd;
        bus.req_dividend = a;
        bus.req_divisor  = b;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic expect_wb(input string name, input logic [4:0] rd,
                             input logic [31:0] data, input int at);
        exp_t e;
        e.name = name;
        e.rd   = rd;
        e.data = data;
        e.at   = at;
        sbq.push_back(e);
    endtask

    // Present one instruction and hold it while EX is stalled
    task automatic issue(input string name, input logic sign, input logic rem,
                         input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res,
                         input bit bypass);
        int stalls = 0;
        int starts = 0;
        bit done   = 1'b0;
        expect_wb(name, rd, res, cyc + (bypass ? 1 : 35));
        drive(sign, rem, rd, a, b);
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.div_start) starts++;
            if (bus.stall) stalls++;
            else done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got stall stuck high, expected release", name);
        end
        check({name, "_stalls"}, stalls, bypass ? 1 : 35);
        check({name, "_starts"}, starts, bypass ? 0 : 34);
        step();
    endtask

    task automatic check_quiet(input string name);
        check({name, "_stall"}, 32'(bus.stall), 32'd0);
        check({name, "_start"}, 32'(bus.div_start), 32'd0);
        check({name, "_wbv"}, 32'(bus.wb_valid), 32'd0);
        check({name, "_wbdata"}, bus.wb_data, 32'd0);
        check({name, "_wbrd"}, 32'(bus.wb_rd), 32'd0);
        check({name, "_dvd"}, bus.div_dividend, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_sign     = 1'b0;
        bus.req_rem      = 1'b0;
        bus.req_rd       = 5'd0;
        bus.req_dividend = 32'd0;
        bus.req_divisor  = 32'd0;
        bus.flush        = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("in_reset");
        step();
        rst_n = 1'b0;
        @(negedge clk);
        check_quiet("post_reset");
        step();

        issue("udiv_100_7", 1'b0, 1'b0, 5'd5, 32'd100, 32'd7, 32'd14, 1'b0);
        idle();
        repeat (3) step();
        @(negedge clk);
        check("hold_data", bus.wb_data, 32'd14);
        check("hold_rd", 32'(bus.wb_rd), 32'd5);
        check("hold_wbv", 32'(bus.wb_valid), 32'd0);
        step();

        issue("srem_m7_2", 1'b1, 1'b1, 5'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        issue("sdiv_m7_2", 1'b1, 1'b0, 5'd7, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        idle();
        step();

        issue("div0_q", 1'b1, 1'b0, 5'd8, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b1);
        issue("div0_r", 1'b1, 1'b1, 5'd9, 32'h1234, 32'd0, 32'h1234, 1'b1);
        issue("divu0_q", 1'b0, 1'b0, 5'd10, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b1);
        issue("ovf_q", 1'b1, 1'b0, 5'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        issue("ovf_r", 1'b1, 1'b1, 5'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
        issue("divu_big", 1'b0, 1'b0, 5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
        issue("remu_big", 1'b0, 1'b1, 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        idle();
        step();

        // flush during DONE leaves the committed result alone
        expect_wb("flush_in_done", 5'd15, 32'd5, cyc + 1);
        drive(1'b0, 1'b1, 5'd15, 32'd5, 32'd0);
        step();
        bus.flush = 1'b1;
        step();
        idle();
        step();

        // flush in IDLE blocks acceptance
        drive(1'b0, 1'b0, 5'd16, 32'd9, 32'd3);
        bus.flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("idle_flush%0d_stall", i), 32'(bus.stall), 32'd0);
            check($sformatf("idle_flush%0d_start", i), 32'(bus.div_start), 32'd0);
            step();
        end
        bus.flush = 1'b0;
        issue("div_9_3_a", 1'b0, 1'b0, 5'd16, 32'd9, 32'd3, 32'd3, 1'b0);
        idle();
        step();

        // flush at N+20 kills the division
        drive(1'b0, 1'b0, 5'd17, 32'd100, 32'd7);
        repeat (20) step();
        bus.flush = 1'b1;
        step();
        idle();
        @(negedge clk);
        check("flush20_start", 32'(bus.div_start), 32'd0);
        check("flush20_stall", 32'(bus.stall), 32'd0);
        step();
        issue("div_9_3_b", 1'b0, 1'b0, 5'd18, 32'd9, 32'd3, 32'd3, 1'b0);
        idle();
        step();

        // flush on the same edge as div_done still wins
        drive(1'b0, 1'b0, 5'd19, 32'd100, 32'd7);
        repeat (34) step();
        bus.flush = 1'b1;
        step();
        idle();
        @(negedge clk);
        check("flush_done_wbv", 32'(bus.wb_valid), 32'd0);
        check("flush_done_start", 32'(bus.div_start), 32'd0);
        step();

        // back-to-back, req_valid held across DONE
        issue("b2b_1000_10", 1'b0, 1'b0, 5'd20, 32'd1000, 32'd10, 32'd100, 1'b0);
        issue("b2b_rem_by0", 1'b1, 1'b1, 5'd21, 32'd5, 32'd0, 32'd5, 1'b1);
        issue("b2b_m100_7", 1'b1, 1'b0, 5'd22, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0);
        idle();
        step();

        // reset while BUSY aborts like flush and clears writeback
        drive(1'b0, 1'b0, 5'd23, 32'd100, 32'd7);
        repeat (10) step();
        rst_n = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rst_busy_stall", 32'(bus.stall), 32'd0);
        check("rst_busy_start", 32'(bus.div_start), 32'd0);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        check_quiet("after_busy_reset");
        repeat (40) step();

        issue("div_9_3_c", 1'b0, 1'b0, 5'd24, 32'd9, 32'd3, 32'd3, 1'b0);
        idle();
        repeat (5) step();
        check("sb_empty", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
